dmem_arbiter: RTL and testbench

//  Shares the single byte-addressed data memory between two requesters: port 0 (core load/store unit)
//  and port 1 (debug/program loader). Captures one request at a time and drives the memory's

---
 rtl/dmem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose  : shares one byte-addressed data memory between port 0 (core LSU) and port 1 (debug/loader).
// Latency  : ready in grant cycle N, memory strobe N+1, rvalid N+2 (illegal access: rvalid N+1, no strobe).
// Backpress: one request in flight; no pX_ready outside IDLE, loser of a tie keeps req and wins next IDLE.
//
// Parameters
//   MEM_BYTES : memory size in bytes; any byte of an access at or beyond it is an error
//   ARB_MODE  : 0 = round-robin between simultaneous requesters, 1 = port 0 always wins
// Build option
//   DMEM_ALIGN_CHECK_EN : when defined, misaligned half/word accesses get an error response
//                         and never reach memory; when undefined they pass through unchanged.
// Ports
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   pX_req/we/addr/wdata/ctrl   request side, held stable by the requester until pX_ready
//   pX_ready                    request accepted this cycle (combinational from state/req)
//   pX_rvalid/rdata/err         one-cycle response; rdata is 0 for stores and errors
//   mem_address/datawr/dmwr/dmctrl  memory drive, non-zero only in ACCESS
//   mem_datard                  combinational read data from memory, sampled at end of ACCESS
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned ARB_MODE  = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_ctrl,
    output logic        p0_ready,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_ctrl,
    output logic        p1_ready,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_datawr,
    output logic        mem_dmwr,
    output logic [2:0]  mem_dmctrl,
    input  logic [31:0] mem_datard
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Captured request, valid from the grant edge until the response has been sent.
    logic        cap_we;
    logic        cap_port;
    logic        cap_err;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_ctrl;
    logic [31:0] rdata_q;

    // Port granted most recently; reset to 1 so port 0 wins the first tie.
    logic        rr_last;

    logic        gnt0;
    logic        gnt1;
    logic        grant;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_ctrl;

    logic [2:0]  sel_size;
    logic        ctrl_bad;
    logic        range_bad;
    logic        align_bad;
    logic        sel_err;
    logic [32:0] last_byte;

    // ------------------------------------------------------------------
    // Arbitration: only evaluated in IDLE, so ready never rises elsewhere.
    // ------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (p0_req && p1_req) begin
                if ((ARB_MODE == 1) || rr_last) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (p0_req) begin
                gnt0 = 1'b1;
            end else if (p1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign grant     = gnt0 | gnt1;
    assign sel_we    = gnt1 ? p1_we    : p0_we;
    assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
    assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
    assign sel_ctrl  = gnt1 ? p1_ctrl  : p0_ctrl;

    // ------------------------------------------------------------------
    // Legality of the selected request.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_bad = 1'b0;
        sel_size = 3'd1;
        case (sel_ctrl)
            3'b000, 3'b100: sel_size = 3'd1;
            3'b001, 3'b101: sel_size = 3'd2;
            3'b010:         sel_size = 3'd4;
            default: begin
                sel_size = 3'd1;
                ctrl_bad = 1'b1;
            end
        endcase
    end

    // Last touched byte in 33 bits: an address near 2^32 must not wrap round to a small legal one.
    assign last_byte = {1'b0, sel_addr} + {30'd0, sel_size} - 33'd1;
    assign range_bad = (last_byte >= 33'(MEM_BYTES));

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_bad = ((sel_size == 3'd2) && sel_addr[0]) ||
                       ((sel_size == 3'd4) && (sel_addr[1:0] != 2'b00));
`else
    // Misaligned accesses go to memory as-is; the memory assembles the bytes.
    assign align_bad = 1'b0;
`endif

    assign sel_err = ctrl_bad | range_bad | align_bad;

    // ------------------------------------------------------------------
    // State register and capture.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            cap_we    <= 1'b0;
            cap_port  <= 1'b0;
            cap_err   <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_ctrl  <= 3'd0;
            rdata_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                cap_we    <= sel_we;
                cap_port  <= gnt1;
                cap_err   <= sel_err;
                cap_addr  <= sel_addr;
                cap_wdata <= sel_wdata;
                cap_ctrl  <= sel_ctrl;
                rr_last   <= gnt1;
                // Cleared here so an error response, which skips ACCESS, returns 0.
                rdata_q   <= 32'd0;
            end
            if (state == ACCESS) begin
                rdata_q <= cap_we ? 32'd0 : mem_datard;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Memory drive is decoded from the state
    // register so an asynchronous reset drops mem_dmwr immediately.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        p0_ready    = gnt0;
        p1_ready    = gnt1;
        p0_rvalid   = 1'b0;
        p1_rvalid   = 1'b0;
        p0_rdata    = 32'd0;
        p1_rdata    = 32'd0;
        p0_err      = 1'b0;
        p1_err      = 1'b0;
        mem_address = 32'd0;
        mem_datawr  = 32'd0;
        mem_dmwr    = 1'b0;
        mem_dmctrl  = 3'd0;

        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = sel_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_address = cap_addr;
                mem_datawr  = cap_wdata;
                mem_dmwr    = cap_we;
                mem_dmctrl  = cap_ctrl;
                state_nxt   = RESP;
            end
            RESP: begin
                if (cap_port) begin
                    p1_rvalid = 1'b1;
                    p1_rdata  = rdata_q;
                    p1_err    = cap_err;
                end else begin
                    p0_rvalid = 1'b1;
                    p0_rdata  = rdata_q;
                    p0_err    = cap_err;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]  p0_ctrl, p1_ctrl;

    logic        p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, mem_datawr, mem_datard;
    logic        mem_dmwr;
    logic [2:0]  mem_dmctrl;

    logic        d1_p0_ready, d1_p0_rvalid, d1_p0_err, d1_p1_ready, d1_p1_rvalid, d1_p1_err;
    logic [31:0] d1_p0_rdata, d1_p1_rdata, d1_mem_address, d1_mem_datawr;
    logic        d1_mem_dmwr;
    logic [2:0]  d1_mem_dmctrl;

    int total = 0;
    int bad   = 0;
    int model_last = 1;

    // Memory device seen by the round-robin DUT, and the bench's own expected memory contents.
    logic [7:0] env_mem [0:4095] = '{default: 8'h00};
    logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(4096), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ctrl(p0_ctrl),
        .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ctrl(p1_ctrl),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_address(mem_address), .mem_datawr(mem_datawr), .mem_dmwr(mem_dmwr),
        .mem_dmctrl(mem_dmctrl), .mem_datard(mem_datard)
    );

    dmem_arbiter #(.MEM_BYTES(4096), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ctrl(p0_ctrl),
        .p0_ready(d1_p0_ready), .p0_rvalid(d1_p0_rvalid), .p0_rdata(d1_p0_rdata), .p0_err(d1_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ctrl(p1_ctrl),
        .p1_ready(d1_p1_ready), .p1_rvalid(d1_p1_rvalid), .p1_rdata(d1_p1_rdata), .p1_err(d1_p1_err),
        .mem_address(d1_mem_address), .mem_datawr(d1_mem_datawr), .mem_dmwr(d1_mem_dmwr),
        .mem_dmctrl(d1_mem_dmctrl), .mem_datard(32'h0)
    );

    // Little-endian byte memory honouring dmctrl, combinational read, write on rising edge.
    logic [11:0] ea;
    logic [7:0]  b0, b1, b2, b3;
    always_comb begin
        ea = mem_address[11:0];
        b0 = env_mem[ea];
        b1 = env_mem[ea + 12'd1];
        b2 = env_mem[ea + 12'd2];
        b3 = env_mem[ea + 12'd3];
        case (mem_dmctrl)
            3'b000:  mem_datard = {{24{b0[7]}}, b0};
            3'b001:  mem_datard = {{16{b1[7]}}, b1, b0};
            3'b100:  mem_datard = {24'd0, b0};
            3'b101:  mem_datard = {16'd0, b1, b0};
            default: mem_datard = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_dmwr) begin
            env_mem[ea] <= mem_datawr[7:0];
            if (mem_dmctrl[1:0] != 2'b00) env_mem[ea + 12'd1] <= mem_datawr[15:8];
            if (mem_dmctrl[1:0] == 2'b10) begin
                env_mem[ea + 12'd2] <= mem_datawr[23:16];
                env_mem[ea + 12'd3] <= mem_datawr[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic [2:0] c);
        if (c == 3'b011 || c == 3'b110 || c == 3'b111) return 1'b1;
        if (64'(a) + 64'(size_of(c)) > 64'd4096) return 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        if (size_of(c) == 2 && a[0]) return 1'b1;
        if (size_of(c) == 4 && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = size_of(c);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[11:0]) + i];
        if (!c[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        for (int i = 0; i < size_of(c); i++) ref_mem[int'(a[11:0]) + i] = d[8*i +: 8];
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_req();
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    // One request on one port; waits for the grant, then watches three cycles.
    task automatic txn(input string tag, input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] ctrl,
                       input logic [31:0] exp_rd, input logic exp_e);
        logic got, e;
        logic [31:0] rd;
        logic [3:0] dm_mask, rv_mask;
        logic other_rv;
        int waitc;
        @(negedge clk);
        if (port == 1) begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_ctrl = ctrl; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_ctrl = ctrl; p0_req = 1'b1;
        end
        waitc = 0;
        #1;
        got = (port == 1) ? p1_ready : p0_ready;
        while (!got && waitc < 20) begin
            @(negedge clk);
            #1;
            got = (port == 1) ? p1_ready : p0_ready;
            waitc++;
        end
        chk({tag, " grant"}, {31'd0, got}, 32'd1);
        if (!got) begin
            drop_req();
            return;
        end
        model_last = port;
        dm_mask = {3'b000, mem_dmwr};
        rv_mask = 4'd0;
        other_rv = 1'b0;
        rd = 32'hx;
        e = 1'bx;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) drop_req();
            #1;
            if (mem_dmwr) dm_mask[k] = 1'b1;
            if (k == 1 && !exp_e) begin
                chk({tag, " mem_address"}, mem_address, addr);
                chk({tag, " mem_dmctrl"}, {29'd0, mem_dmctrl}, {29'd0, ctrl});
                if (we) chk({tag, " mem_datawr"}, mem_datawr, wdata);
            end
            if ((port == 1) ? p1_rvalid : p0_rvalid) begin
                rv_mask[k] = 1'b1;
                rd = (port == 1) ? p1_rdata : p0_rdata;
                e  = (port == 1) ? p1_err : p0_err;
            end
            if ((port == 1) ? p0_rvalid : p1_rvalid) other_rv = 1'b1;
        end
        chk({tag, " dmwr cycles"}, {28'd0, dm_mask}, (we && !exp_e) ? 32'd2 : 32'd0);
        chk({tag, " rvalid cycle"}, {28'd0, rv_mask}, exp_e ? 32'd2 : 32'd4);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, {31'd0, e}, {31'd0, exp_e});
        chk({tag, " other port rvalid"}, {31'd0, other_rv}, 32'd0);
        if (we && !exp_e) model_store(addr, wdata, ctrl);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int grants, both_rdy, dual_rv, d1_p0, d1_p1, winner;
        logic [31:0] ra, rw, erd;
        logic [2:0] rc;
        logic rwe, ee;
        int rport, sel;

        rst_n = 1'b0;
        drop_req();
        p0_we = 0; p1_we = 0; p0_addr = 0; p1_addr = 0;
        p0_wdata = 0; p1_wdata = 0; p0_ctrl = 0; p1_ctrl = 0;

        @(negedge clk);
        #1;
        chk("reset flags", {24'd0, p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_dmwr, 1'b0}, 32'd0);
        chk("reset p0_rdata", p0_rdata, 32'd0);
        chk("reset p1_rdata", p1_rdata, 32'd0);
        chk("reset mem_address", mem_address, 32'd0);
        chk("reset mem_datawr", mem_datawr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: basic store/load and sign/zero extension.
        txn("sw10",   0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        txn("lw10",   0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        txn("sb20",   1, 1'b1, 32'h20, 32'hAAAAAA80, 3'b000, 32'h0, 1'b0);
        txn("lb20",   1, 1'b0, 32'h20, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
        txn("lbu20",  1, 1'b0, 32'h20, 32'h0, 3'b100, 32'h00000080, 1'b0);
        txn("lhu20",  1, 1'b0, 32'h20, 32'h0, 3'b101, 32'h00000080, 1'b0);
        // Directed: boundaries and illegal encodings.
        txn("lwFFE",  0, 1'b0, 32'hFFE, 32'h0, 3'b010, 32'h0, 1'b1);
        txn("ctrl011", 0, 1'b0, 32'h40, 32'h0, 3'b011, 32'h0, 1'b1);
        txn("swwrap", 1, 1'b1, 32'hFFFFFFFE, 32'h55555555, 3'b010, 32'h0, 1'b1);
        txn("shFFF",  0, 1'b1, 32'hFFF, 32'h1234, 3'b001, 32'h0, 1'b1);
        txn("swFFC",  1, 1'b1, 32'hFFC, 32'h11223344, 3'b010, 32'h0, 1'b0);
        txn("lwFFC",  1, 1'b0, 32'hFFC, 32'h0, 3'b010, 32'h11223344, 1'b0);
        // Directed: misaligned halfword.
        txn("sb3",    0, 1'b1, 32'h3, 32'h34, 3'b000, 32'h0, 1'b0);
        txn("sb4",    0, 1'b1, 32'h4, 32'h92, 3'b000, 32'h0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        txn("lh3",    0, 1'b0, 32'h3, 32'h0, 3'b001, 32'h0, 1'b1);
`else
        txn("lh3",    0, 1'b0, 32'h3, 32'h0, 3'b001, 32'hFFFF9234, 1'b0);
`endif

        // Reset asserted during the memory cycle of a store.
        @(negedge clk);
        p0_we = 1'b1; p0_addr = 32'h100; p0_wdata = 32'h12345678; p0_ctrl = 3'b010; p0_req = 1'b1;
        #1;
        chk("rst-mid grant", {31'd0, p0_ready}, 32'd1);
        @(negedge clk);
        drop_req();
        #1;
        chk("rst-mid dmwr before", {31'd0, mem_dmwr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst-mid dmwr after", {31'd0, mem_dmwr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        dual_rv = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (p0_rvalid || p1_rvalid) dual_rv++;
            @(negedge clk);
        end
        chk("rst-mid no rvalid", dual_rv, 0);
        txn("post-rst lw10", 0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

        // Both ports request continuously.
        @(negedge clk);
        p0_we = 1'b0; p0_addr = 32'h10; p0_ctrl = 3'b010; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 32'h20; p1_ctrl = 3'b100; p1_req = 1'b1;
        grants = 0; both_rdy = 0; dual_rv = 0; d1_p0 = 0; d1_p1 = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            #1;
            if (p0_ready && p1_ready) both_rdy++;
            if (p0_rvalid && p1_rvalid) dual_rv++;
            if (d1_p0_ready) d1_p0++;
            if (d1_p1_ready) d1_p1++;
            if (p0_ready || p1_ready) begin
                winner = p1_ready ? 1 : 0;
                chk("rr winner", winner, 1 - model_last);
                model_last = winner;
                grants++;
            end
            @(negedge clk);
        end
        drop_req();
        chk("rr grant count", grants, 6);
        chk("rr single ready", both_rdy, 0);
        chk("rr single rvalid", dual_rv, 0);
        chk("fixed p1 never", d1_p1, 0);
        chk("fixed p0 wins", {31'd0, d1_p0 >= 3}, 32'd1);
        repeat (4) @(negedge clk);

        // Randomized single-port traffic checked against the model.
        for (int t = 0; t < 60; t++) begin
            rport = $urandom_range(0, 1);
            rwe = 1'($urandom_range(0, 1));
            rc = 3'($urandom_range(0, 7));
            rw = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = 32'($urandom_range(0, 63));
            else if (sel < 9)  ra = 32'hFF0 + 32'($urandom_range(0, 15));
            else               ra = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            ee = model_err(ra, rc);
            erd = (ee || rwe) ? 32'd0 : model_load(ra, rc);
            txn("rand", rport, rwe, ra, rw, rc, erd, ee);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
